// File: rtl/fft_r2_sched_if.sv
// Handshake and address bus between the radix-2 FFT scheduler and the RAM/ROM/butterfly datapath.
// The master modport is the scheduler side, and the slave modport is the wrapper/datapath side.
interface fft_r2_sched_if #(
  parameter int LOG2N = 8
);
  logic                       start;
  logic                       busy;
  logic                       done;
  logic [$clog2(LOG2N)-1:0]   stage;
  logic                       rd_en;
  logic [LOG2N-1:0]           rd_addr_a;
  logic [LOG2N-1:0]           rd_addr_b;
  logic [LOG2N-2:0]           tw_addr;
  logic                       bf_valid;
  logic                       wr_en;
  logic [LOG2N-1:0]           wr_addr_a;
  logic [LOG2N-1:0]           wr_addr_b;
  logic                       out_valid;
  logic [LOG2N-1:0]           out_addr;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid, wr_en, wr_addr_a, wr_addr_b, out_valid, out_addr
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid, wr_en, wr_addr_a, wr_addr_b, out_valid, out_addr
  );
endinterface

// File: rtl/fft_r2_sched.sv
// Sequencer for a single-butterfly, in-place, radix-2 DIF FFT: read/twiddle/write addressing per stage.
// Define FFT_SCHED_BITREV_EN to add an OUT state that streams bit-reversed readout addresses before done.
module fft_r2_sched #(
  parameter int LOG2N       = 8,
  parameter int MEM_LATENCY = 1,
  parameter int BF_LATENCY  = 3
) (
  input logic              clk,
  input logic              rst,
  fft_r2_sched_if.master   bus
);

  localparam int N  = 1 << LOG2N;
  localparam int D  = MEM_LATENCY + BF_LATENCY;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = $clog2(D + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
`ifdef FFT_SCHED_BITREV_EN
  localparam logic [2:0] S_OUT   = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [LOG2N-1:0] HALF_LAST  = LOG2N'(N / 2 - 1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(D - 1);
`ifdef FFT_SCHED_BITREV_EN
  localparam logic [LOG2N-1:0] FULL_LAST  = LOG2N'(N - 1);
`endif

  logic [2:0]       state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drain_q, drain_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [LOG2N-2:0] tw_addr_q, tw_addr_d;
  logic             out_valid_q, out_valid_d;
  logic [LOG2N-1:0] out_addr_q, out_addr_d;

  logic [D-1:0]            en_pipe_q, en_pipe_d;
  logic [D-1:0][LOG2N-1:0] a_pipe_q, a_pipe_d;
  logic [D-1:0][LOG2N-1:0] b_pipe_q, b_pipe_d;

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] j_idx;
  logic [LOG2N-1:0] g_idx;
  logic [LOG2N-1:0] base_a;
  int               st;

`ifdef FFT_SCHED_BITREV_EN
  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction
`endif

  // Each DRAIN lasts exactly the read-to-write latency, so the next stage never reads stale data.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          stage_d = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == HALF_LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          cnt_d   = '0;
          if (stage_q == STAGE_LAST) begin
            stage_d = '0;
`ifdef FFT_SCHED_BITREV_EN
            state_d = S_OUT;
`else
            state_d = S_DONE;
`endif
          end else begin
            stage_d = stage_q + 1'b1;
            state_d = S_RUN;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
`ifdef FFT_SCHED_BITREV_EN
      S_OUT: begin
        if (cnt_q == FULL_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
        cnt_d   = '0;
        drain_d = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so that every port comes straight from a flop.
  always_comb begin
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    rd_en_d     = (state_d == S_RUN);
    rd_addr_a_d = '0;
    rd_addr_b_d = '0;
    tw_addr_d   = '0;
    st          = int'(stage_d);
    span        = LOG2N'(1) << (LOG2N - 1 - st);
    j_idx       = cnt_d & (span - 1'b1);
    g_idx       = cnt_d >> (LOG2N - 1 - st);
    base_a      = (g_idx << (LOG2N - st)) | j_idx;
    if (rd_en_d) begin
      rd_addr_a_d = base_a;
      rd_addr_b_d = base_a + span;
      tw_addr_d   = (LOG2N-1)'(j_idx << st);
    end
  end

`ifdef FFT_SCHED_BITREV_EN
  always_comb begin
    out_valid_d = (state_d == S_OUT);
    out_addr_d  = '0;
    if (out_valid_d) begin
      out_addr_d = bit_rev(cnt_d);
    end
  end
`else
  always_comb begin
    out_valid_d = 1'b0;
    out_addr_d  = '0;
  end
`endif

  // The write addresses ride along with the read strobe through the memory and butterfly latency.
  always_comb begin
    en_pipe_d    = '0;
    a_pipe_d     = '0;
    b_pipe_d     = '0;
    en_pipe_d[0] = rd_en_q;
    a_pipe_d[0]  = rd_addr_a_q;
    b_pipe_d[0]  = rd_addr_b_q;
    for (int i = 1; i < D; i++) begin
      en_pipe_d[i] = en_pipe_q[i-1];
      a_pipe_d[i]  = a_pipe_q[i-1];
      b_pipe_d[i]  = b_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      en_pipe_q   <= '0;
      a_pipe_q    <= '0;
      b_pipe_q    <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      en_pipe_q   <= en_pipe_d;
      a_pipe_q    <= a_pipe_d;
      b_pipe_q    <= b_pipe_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.bf_valid  = en_pipe_q[MEM_LATENCY-1];
  assign bus.wr_en     = en_pipe_q[D-1];
  assign bus.wr_addr_a = a_pipe_q[D-1];
  assign bus.wr_addr_b = b_pipe_q[D-1];
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_fft_r2_sched.sv
// Directed bench for fft_r2_sched: a default N=256 instance plus a small N=8 instance.
// The N=8 expectations switch with FFT_SCHED_BITREV_EN.
module tb_fft_r2_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_r2_sched_if #(.LOG2N(8)) bus ();
  fft_r2_sched_if #(.LOG2N(3)) sbus ();

  fft_r2_sched #(.LOG2N(8), .MEM_LATENCY(1), .BF_LATENCY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fft_r2_sched #(.LOG2N(3), .MEM_LATENCY(1), .BF_LATENCY(3)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  typedef struct {
    int         cyc;
    logic       rd_en;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] tw;
    logic [2:0] stage;
    logic       busy;
    logic       done;
    logic       bf_valid;
    logic       wr_en;
    logic [7:0] wa;
    logic [7:0] wb;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int c, logic r, int a, int b, int tw, int st, logic bsy,
                              logic dn, logic bf, logic wr, int wa, int wb);
    vec_t v;
    v.cyc = c; v.rd_en = r; v.a = 8'(a); v.b = 8'(b); v.tw = 7'(tw); v.stage = 3'(st);
    v.busy = bsy; v.done = dn; v.bf_valid = bf; v.wr_en = wr; v.wa = 8'(wa); v.wb = 8'(wb);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s_big, input logic s_small, input logic r);
    bus.start  = s_big;
    sbus.start = s_small;
    rst        = r;
  endtask

  task automatic checkVec(input vec_t v);
    string p;
    p = $sformatf("c%0d", v.cyc);
    checkOutput({p, " rd_en"},     32'(bus.rd_en),     32'(v.rd_en));
    checkOutput({p, " rd_addr_a"}, 32'(bus.rd_addr_a), 32'(v.a));
    checkOutput({p, " rd_addr_b"}, 32'(bus.rd_addr_b), 32'(v.b));
    checkOutput({p, " tw_addr"},   32'(bus.tw_addr),   32'(v.tw));
    checkOutput({p, " stage"},     32'(bus.stage),     32'(v.stage));
    checkOutput({p, " busy"},      32'(bus.busy),      32'(v.busy));
    checkOutput({p, " done"},      32'(bus.done),      32'(v.done));
    checkOutput({p, " bf_valid"},  32'(bus.bf_valid),  32'(v.bf_valid));
    checkOutput({p, " wr_en"},     32'(bus.wr_en),     32'(v.wr_en));
    checkOutput({p, " wr_addr_a"}, 32'(bus.wr_addr_a), 32'(v.wa));
    checkOutput({p, " wr_addr_b"}, 32'(bus.wr_addr_b), 32'(v.wb));
  endtask

  task automatic checkAllZero(input string p);
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkVec(z);
    checkOutput({p, " out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({p, " out_addr"},  32'(bus.out_addr),  32'd0);
  endtask

  initial begin
    int idx;
    int done_cnt;
    int done_cyc;
    int extra;
    int wr_seen;
    int out_seen;
    logic [2:0] rev_exp [8];

    vecs.push_back(mk(1,    1, 0,   128, 0,   0, 1, 0, 0, 0, 0,   0));
    vecs.push_back(mk(2,    1, 1,   129, 1,   0, 1, 0, 1, 0, 0,   0));
    vecs.push_back(mk(5,    1, 4,   132, 4,   0, 1, 0, 1, 1, 0,   128));
    vecs.push_back(mk(128,  1, 127, 255, 127, 0, 1, 0, 1, 1, 123, 251));
    vecs.push_back(mk(129,  0, 0,   0,   0,   0, 1, 0, 1, 1, 124, 252));
    vecs.push_back(mk(132,  0, 0,   0,   0,   0, 1, 0, 0, 1, 127, 255));
    vecs.push_back(mk(133,  1, 0,   64,  0,   1, 1, 0, 0, 0, 0,   0));
    vecs.push_back(mk(134,  1, 1,   65,  2,   1, 1, 0, 1, 0, 0,   0));
    vecs.push_back(mk(197,  1, 128, 192, 0,   1, 1, 0, 1, 1, 60,  124));
    vecs.push_back(mk(925,  1, 0,   1,   0,   7, 1, 0, 0, 0, 0,   0));
    vecs.push_back(mk(926,  1, 2,   3,   0,   7, 1, 0, 1, 0, 0,   0));
    vecs.push_back(mk(1052, 1, 254, 255, 0,   7, 1, 0, 1, 1, 246, 247));
    vecs.push_back(mk(1056, 0, 0,   0,   0,   7, 1, 0, 0, 1, 254, 255));
    vecs.push_back(mk(1057, 0, 0,   0,   0,   0, 0, 1, 0, 0, 0,   0));
    vecs.push_back(mk(1058, 0, 0,   0,   0,   0, 0, 0, 0, 0, 0,   0));

    rev_exp[0] = 3'd0; rev_exp[1] = 3'd4; rev_exp[2] = 3'd2; rev_exp[3] = 3'd6;
    rev_exp[4] = 3'd1; rev_exp[5] = 3'd5; rev_exp[6] = 3'd3; rev_exp[7] = 3'd7;

    applyStimulus(0, 0, 1);
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    applyStimulus(0, 0, 0);
    @(negedge clk);

    // Full default transform; a second start during the run must be ignored.
    $display("[TB] full transform, N=256");
    applyStimulus(1, 0, 0);
    idx = 0; done_cnt = 0; done_cyc = -1; extra = 0;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      applyStimulus(c == 300, 0, 0);
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c >= 129 && c <= 132) checkOutput($sformatf("c%0d drain rd_en", c), 32'(bus.rd_en), 32'd0);
      if (idx < vecs.size() && vecs[idx].cyc == c) begin
        checkVec(vecs[idx]);
        idx++;
      end
      if (c > 1058 && (bus.busy || bus.rd_en || bus.wr_en)) extra++;
    end
    checkOutput("done_count", 32'(done_cnt), 32'd1);
    checkOutput("done_cycle", 32'(done_cyc), 32'd1057);
    checkOutput("no_restart", 32'(extra), 32'd0);
    checkOutput("vectors_applied", 32'(idx), 32'(vecs.size()));

    // Mid-transform reset: clears outputs asynchronously and leaves no write behind.
    $display("[TB] reset during transform");
    applyStimulus(1, 0, 0);
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 0);
    end
    checkOutput("c500 wr_en before reset", 32'(bus.wr_en), 32'd1);
    applyStimulus(0, 0, 1);
    #1;
    checkAllZero("async reset");
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 0);
    wr_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.wr_en || bus.busy || bus.rd_en) wr_seen++;
    end
    checkOutput("idle after reset", 32'(wr_seen), 32'd0);
    applyStimulus(1, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0);
    checkVec(mk(1, 1, 0, 128, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkVec(mk(2, 1, 1, 129, 1, 0, 1, 0, 1, 0, 0, 0));
    applyStimulus(0, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0);
    @(negedge clk);

    // Small instance: address math at N=8 and the optional readout phase.
    $display("[TB] small transform, N=8");
    applyStimulus(0, 1, 0);
    done_cyc = -1; out_seen = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 0);
      if (sbus.done) done_cyc = c;
      if (sbus.out_valid) out_seen++;
      if (c == 4) begin
        checkOutput("s c4 rd_addr_a", 32'(sbus.rd_addr_a), 32'd3);
        checkOutput("s c4 rd_addr_b", 32'(sbus.rd_addr_b), 32'd7);
        checkOutput("s c4 tw_addr",   32'(sbus.tw_addr),   32'd3);
      end
      if (c == 10) begin
        checkOutput("s c10 stage",     32'(sbus.stage),     32'd1);
        checkOutput("s c10 rd_addr_a", 32'(sbus.rd_addr_a), 32'd1);
        checkOutput("s c10 rd_addr_b", 32'(sbus.rd_addr_b), 32'd3);
        checkOutput("s c10 tw_addr",   32'(sbus.tw_addr),   32'd2);
      end
      if (c == 20) begin
        checkOutput("s c20 stage",     32'(sbus.stage),     32'd2);
        checkOutput("s c20 rd_addr_a", 32'(sbus.rd_addr_a), 32'd6);
        checkOutput("s c20 rd_addr_b", 32'(sbus.rd_addr_b), 32'd7);
      end
`ifdef FFT_SCHED_BITREV_EN
      if (c >= 25 && c <= 32) begin
        checkOutput($sformatf("s c%0d out_valid", c), 32'(sbus.out_valid), 32'd1);
        checkOutput($sformatf("s c%0d out_addr", c), 32'(sbus.out_addr), 32'(rev_exp[c-25]));
        checkOutput($sformatf("s c%0d busy", c), 32'(sbus.busy), 32'd1);
      end
`endif
    end
`ifdef FFT_SCHED_BITREV_EN
    checkOutput("s out_valid count", 32'(out_seen), 32'd8);
    checkOutput("s done_cycle", 32'(done_cyc), 32'd33);
`else
    checkOutput("s out_valid count", 32'(out_seen), 32'd0);
    checkOutput("s done_cycle", 32'(done_cyc), 32'd25);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
